// File: rtl/logic_right_shift_seq_128bit.sv
// Sequential logical right shift: parallel load, then one bit per clock under start/busy/done.
// Optional macro SERIAL_IN_EN adds a serial_in port that fills Q[WIDTH-1] on each shift.
module logic_right_shift_seq_128bit #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
`ifdef SERIAL_IN_EN
  input  logic             serial_in,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state, state_n;
  logic [CNT_W-1:0] remaining, rem_n, amt_clamp;
  logic [WIDTH-1:0] q_n;
  logic             so_n, fill;

`ifdef SERIAL_IN_EN
  assign fill = serial_in;
`else
  assign fill = 1'b0;
`endif

  // Distances past the register width leave nothing to shift beyond WIDTH steps.
  assign amt_clamp = (amount > WIDTH_C) ? WIDTH_C : amount;

  always_comb begin
    state_n = state;
    q_n     = Q;
    so_n    = serial_out;
    rem_n   = remaining;
    unique case (state)
      IDLE: begin
        if (load) begin
          q_n = D;
        end else if (start) begin
          if (amount == '0) begin
            state_n = DONE;
          end else begin
            rem_n   = amt_clamp;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        q_n   = {fill, Q[WIDTH-1:1]};
        so_n  = Q[0];
        rem_n = remaining - CNT_W'(1);
        if (remaining <= CNT_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      Q          <= '0;
      serial_out <= 1'b0;
      remaining  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      Q          <= q_n;
      serial_out <= so_n;
      remaining  <= rem_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
    end
  end

endmodule
